axi_dual_channel_converter: RTL and testbench

- Parametrised successor to the single-FSM cache-to-AXI converter.
- Bridges PORT_NUM cache bus ports onto one AXI4 master with independent read and write engines, so one read burst and one write burst can be in flight concurrently.
- Adds configurable data/address width and burst length, per-port AXI IDs, write-completion acknowledgement, bus-error reporting, and a read-after-write line hazard stall.
- Sits between the I/D cache (and uncached) request ports and the top-level AXI crossbar.

---
 rtl/axi_dual_channel_converter.sv | 204 ++++++++++++++++++++
 tb/tb_axi_dual_channel_converter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dual_channel_converter.sv
// axi_dual_channel_converter: bridges PORT_NUM cache ports onto one AXI4 master with
// independent round-robin read and write engines and a read-after-write line stall.
module axi_dual_channel_converter #(
    parameter int PORT_NUM  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORT_NUM-1:0]          req_valid,
    input  logic [PORT_NUM-1:0]          req_write,
    input  logic [PORT_NUM-1:0]          req_burst,
    input  logic [PORT_NUM-1:0]          req_cached,
    input  logic [PORT_NUM*ADDR_W-1:0]   req_addr,
    input  logic [PORT_NUM*DATA_W-1:0]   req_wdata,
    input  logic [PORT_NUM*DATA_W/8-1:0] req_wstrb,
    input  logic [PORT_NUM-1:0]          req_data_ok,
    output logic [PORT_NUM-1:0]          resp_ready,
    output logic [PORT_NUM-1:0]          resp_data_ok,
    output logic [PORT_NUM-1:0]          resp_data_last,
    output logic [PORT_NUM-1:0]          resp_err,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic [ID_W-1:0]              m_ar_id,
    output logic [ADDR_W-1:0]            m_ar_addr,
    output logic [7:0]                   m_ar_len,
    output logic [2:0]                   m_ar_size,
    output logic [1:0]                   m_ar_burst,
    output logic [3:0]                   m_ar_cache,
    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    input  logic [ID_W-1:0]              m_r_id,
    input  logic [DATA_W-1:0]            m_r_data,
    input  logic [1:0]                   m_r_resp,
    input  logic                         m_r_last,
    input  logic                         m_r_valid,
    output logic                         m_r_ready,
    output logic [ID_W-1:0]              m_aw_id,
    output logic [ADDR_W-1:0]            m_aw_addr,
    output logic [7:0]                   m_aw_len,
    output logic [2:0]                   m_aw_size,
    output logic [1:0]                   m_aw_burst,
    output logic [3:0]                   m_aw_cache,
    output logic                         m_aw_valid,
    input  logic                         m_aw_ready,
    output logic [DATA_W-1:0]            m_w_data,
    output logic [DATA_W/8-1:0]          m_w_strb,
    output logic                         m_w_last,
    output logic                         m_w_valid,
    input  logic                         m_w_ready,
    input  logic [ID_W-1:0]              m_b_id,
    input  logic [1:0]                   m_b_resp,
    input  logic                         m_b_valid,
    output logic                         m_b_ready
);
    localparam int PW   = PORT_NUM > 1 ? $clog2(PORT_NUM) : 1;
    localparam int CW   = $clog2(BURST_LEN);
    localparam int SW   = DATA_W / 8;
    localparam int LOFF = $clog2(BURST_LEN * SW);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic [PW-1:0]     r_rr, w_rr, r_port, w_port, r_gnt, w_gnt;
    logic              r_gnt_v, w_gnt_v, r_acc, w_acc, r_hs, w_hs, b_hs;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_burst, w_burst, r_cached, w_cached, r_err;
    logic [CW-1:0]     w_cnt;
    logic [PORT_NUM-1:0] r_cand, w_cand;
    logic              unused;

    function automatic logic [PW:0] rr_pick(input logic [PORT_NUM-1:0] cand, input logic [PW-1:0] ptr);
        int idx;
        rr_pick = '0;
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % PORT_NUM;
            if (cand[idx]) rr_pick = {1'b1, PW'(idx)};
        end
    endfunction

    // Reads to the line held by an active write are hidden from the read arbiter.
    always_comb begin
        r_cand = '0;
        for (int i = 0; i < PORT_NUM; i++)
            r_cand[i] = req_valid[i] && !req_write[i] && !(w_state != W_IDLE &&
                req_addr[i*ADDR_W+LOFF +: ADDR_W-LOFF] == w_addr[ADDR_W-1:LOFF]);
        w_cand = req_valid & req_write;
    end

    assign {r_gnt_v, r_gnt} = rr_pick(r_cand, r_rr);
    assign {w_gnt_v, w_gnt} = rr_pick(w_cand, w_rr);
    assign r_acc = rst_n && r_state == R_IDLE && r_gnt_v;
    assign w_acc = rst_n && w_state == W_IDLE && w_gnt_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            r_rr     <= '0;
            r_port   <= '0;
            r_addr   <= '0;
            r_burst  <= 1'b0;
            r_cached <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (r_acc) begin
                    r_state  <= R_ADDR;
                    r_rr     <= PW'((int'(r_gnt) + 1) % PORT_NUM);
                    r_port   <= r_gnt;
                    r_addr   <= req_addr[int'(r_gnt)*ADDR_W +: ADDR_W];
                    r_burst  <= req_burst[r_gnt];
                    r_cached <= req_cached[r_gnt];
                    r_err    <= 1'b0;
                end
                R_ADDR: if (m_ar_ready) r_state <= R_DATA;
                R_DATA: if (r_hs) begin
                    r_err <= r_err | m_r_resp[1];
                    if (m_r_last) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            w_rr     <= '0;
            w_port   <= '0;
            w_addr   <= '0;
            w_burst  <= 1'b0;
            w_cached <= 1'b0;
            w_cnt    <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (w_acc) begin
                    w_state  <= W_ADDR;
                    w_rr     <= PW'((int'(w_gnt) + 1) % PORT_NUM);
                    w_port   <= w_gnt;
                    w_addr   <= req_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
                    w_burst  <= req_burst[w_gnt];
                    w_cached <= req_cached[w_gnt];
                end
                W_ADDR: if (m_aw_ready) begin
                    w_state <= W_DATA;
                    w_cnt   <= '0;
                end
                W_DATA: if (w_hs) begin
                    w_cnt <= w_cnt + 1'b1;
                    if (m_w_last) w_state <= W_RESP;
                end
                W_RESP: if (m_b_valid) w_state <= W_IDLE;
            endcase
        end
    end

    assign m_ar_valid = r_state == R_ADDR;
    assign m_ar_id    = ID_W'(r_port);
    assign m_ar_addr  = r_addr;
    assign m_ar_len   = r_burst ? 8'(BURST_LEN - 1) : 8'd0;
    assign m_ar_size  = 3'($clog2(SW));
    assign m_ar_burst = r_burst ? 2'b10 : 2'b01;
    assign m_ar_cache = {2'b00, r_cached, 1'b0};
    assign m_r_ready  = r_state == R_DATA && req_data_ok[r_port];
    assign r_hs       = m_r_ready && m_r_valid;
    assign resp_rdata = m_r_data;

    assign m_aw_valid = w_state == W_ADDR;
    assign m_aw_id    = ID_W'(w_port);
    assign m_aw_addr  = w_addr;
    assign m_aw_len   = w_burst ? 8'(BURST_LEN - 1) : 8'd0;
    assign m_aw_size  = 3'($clog2(SW));
    assign m_aw_burst = w_burst ? 2'b10 : 2'b01;
    assign m_aw_cache = {2'b00, w_cached, 1'b0};
    assign m_w_valid  = w_state == W_DATA && req_data_ok[w_port];
    assign m_w_last   = w_cnt == (w_burst ? CW'(BURST_LEN - 1) : CW'(0));
    assign m_w_data   = req_wdata[int'(w_port)*DATA_W +: DATA_W];
    assign m_w_strb   = req_wstrb[int'(w_port)*SW +: SW];
    assign w_hs       = m_w_valid && m_w_ready;
    assign m_b_ready  = w_state == W_RESP;
    assign b_hs       = m_b_ready && m_b_valid;

    always_comb begin
        resp_ready     = '0;
        resp_data_ok   = '0;
        resp_data_last = '0;
        resp_err       = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            resp_ready[i]     = (r_acc && r_gnt == PW'(i)) || (w_acc && w_gnt == PW'(i));
            resp_data_ok[i]   = (r_hs && r_port == PW'(i)) || (w_hs && w_port == PW'(i));
            resp_data_last[i] = (r_hs && m_r_last && r_port == PW'(i)) || (b_hs && w_port == PW'(i));
            resp_err[i]       = (r_hs && m_r_last && r_port == PW'(i) && (r_err || m_r_resp[1])) ||
                                (b_hs && w_port == PW'(i) && m_b_resp[1]);
        end
    end

    assign unused = ^{m_r_resp[0], m_b_resp[0], m_r_id, m_b_id};

    assert property (@(posedge clk) disable iff (!rst_n) r_hs |-> m_r_id == ID_W'(r_port));
    assert property (@(posedge clk) disable iff (!rst_n) b_hs |-> m_b_id == ID_W'(w_port));
endmodule

// File: tb/tb_axi_dual_channel_converter.sv
// tb_axi_dual_channel_converter: directed cycle-by-cycle bench acting as cache ports and AXI slave.
module tb_axi_dual_channel_converter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_write, req_burst, req_cached, req_data_ok;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  resp_ready, resp_data_ok, resp_data_last, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  m_ar_id, m_aw_id, m_r_id, m_b_id, m_ar_cache, m_aw_cache, m_w_strb;
    logic [31:0] m_ar_addr, m_aw_addr, m_r_data, m_w_data;
    logic [7:0]  m_ar_len, m_aw_len;
    logic [2:0]  m_ar_size, m_aw_size;
    logic [1:0]  m_ar_burst, m_aw_burst, m_r_resp, m_b_resp;
    logic        m_ar_valid, m_ar_ready, m_r_last, m_r_valid, m_r_ready;
    logic        m_aw_valid, m_aw_ready, m_w_last, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi_dual_channel_converter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_burst(req_burst), .req_cached(req_cached),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_data_ok(req_data_ok),
        .resp_ready(resp_ready), .resp_data_ok(resp_data_ok), .resp_data_last(resp_data_last),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_burst(m_ar_burst), .m_ar_cache(m_ar_cache), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
        .m_aw_burst(m_aw_burst), .m_aw_cache(m_aw_cache), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_valid(m_w_valid),
        .m_w_ready(m_w_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid),
        .m_b_ready(m_b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic wr, input logic bu, input logic ca,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
        req_valid[p]          = 1'b1;
        req_write[p]          = wr;
        req_burst[p]          = bu;
        req_cached[p]         = ca;
        req_addr[p*32 +: 32]  = addr;
        req_wdata[p*32 +: 32] = wd;
        req_wstrb[p*4 +: 4]   = st;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic last, input logic [1:0] rs);
        m_r_valid = 1'b1;
        m_r_id    = id;
        m_r_data  = d;
        m_r_last  = last;
        m_r_resp  = rs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_write = '0; req_burst = '0; req_cached = '0; req_data_ok = '0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0; m_r_valid = 0; m_r_id = 0; m_r_data = 0;
        m_r_resp = 0; m_r_last = 0; m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
        // reset: outputs quiet even with a pending request
        req_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", resp_ready, 2'b00);
        check("rst_arv", m_ar_valid, 0);
        check("rst_awv", m_aw_valid, 0);
        check("rst_rrdy", m_r_ready, 0);
        check("rst_wv", m_w_valid, 0);
        check("rst_brdy", m_b_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;
        tick;

        // port0 read burst 0x1000
        set_req(0, 0, 1, 1, 32'h1000, 0, 0);
        req_data_ok = 2'b01;
        #1 check("t1_ready", resp_ready, 2'b01);
        tick;
        req_valid = '0;
        #1 check("t1_arv", m_ar_valid, 1);
        check("t1_araddr", m_ar_addr, 32'h1000);
        check("t1_arlen", m_ar_len, 3);
        check("t1_arburst", m_ar_burst, 2'b10);
        check("t1_arid", m_ar_id, 0);
        check("t1_arsize", m_ar_size, 2);
        check("t1_arcache", m_ar_cache, 4'b0010);
        m_ar_ready = 1'b1;
        m_aw_ready = 1'b1;
        tick;
        #1 check("t1_arv_drop", m_ar_valid, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                req_data_ok = 2'b00;
                r_beat(0, 32'hD0 + i, 0, 0);
                #1 check("t1_stall_rrdy", m_r_ready, 0);
                check("t1_stall_ok", resp_data_ok, 2'b00);
                tick;
                req_data_ok = 2'b01;
            end
            r_beat(0, 32'hD0 + i, i == 3, 0);
            #1 check("t1_ok", resp_data_ok, 2'b01);
            check("t1_data", resp_rdata, 32'hD0 + i);
            check("t1_last", resp_data_last, i == 3 ? 2'b01 : 2'b00);
            check("t1_err", resp_err, 2'b00);
            tick;
        end
        m_r_valid = 1'b0;

        // port1 single write concurrent with port0 single read
        set_req(0, 0, 0, 0, 32'h3000, 0, 0);
        set_req(1, 1, 0, 0, 32'h2004, 32'hCAFEBABE, 4'b0011);
        req_data_ok = 2'b00;
        #1 check("t2_ready", resp_ready, 2'b11);
        tick;
        req_valid = '0;
        #1 check("t2_arv", m_ar_valid, 1);
        check("t2_awv", m_aw_valid, 1);
        check("t2_awaddr", m_aw_addr, 32'h2004);
        check("t2_awid", m_aw_id, 1);
        check("t2_awlen", m_aw_len, 0);
        check("t2_awburst", m_aw_burst, 2'b01);
        check("t2_awcache", m_aw_cache, 4'b0000);
        check("t2_araddr", m_ar_addr, 32'h3000);
        check("t2_arlen", m_ar_len, 0);
        check("t2_arburst", m_ar_burst, 2'b01);
        tick;
        req_data_ok = 2'b11;
        m_w_ready = 1'b1;
        r_beat(0, 32'h55, 1, 0);
        #1 check("t2_wv", m_w_valid, 1);
        check("t2_wlast", m_w_last, 1);
        check("t2_wdata", m_w_data, 32'hCAFEBABE);
        check("t2_wstrb", m_w_strb, 4'b0011);
        check("t2_ok", resp_data_ok, 2'b11);
        check("t2_rlast", resp_data_last, 2'b01);
        check("t2_rdata", resp_rdata, 32'h55);
        tick;
        m_w_ready = 1'b0;
        m_r_valid = 1'b0;
        #1 check("t2_brdy", m_b_ready, 1);
        check("t2_wv_drop", m_w_valid, 0);
        check("t2_nolast", resp_data_last, 2'b00);
        m_b_valid = 1'b1;
        m_b_id = 1;
        m_b_resp = 0;
        #1 check("t2_back", resp_data_last, 2'b10);
        check("t2_berr", resp_err, 2'b00);
        tick;
        m_b_valid = 1'b0;
        #1 check("t2_brdy_drop", m_b_ready, 0);

        // RAW hazard: write burst to line 0x1000 from port1
        req_data_ok = 2'b01;
        set_req(1, 1, 1, 1, 32'h1000, 32'hA0, 4'hF);
        #1 check("t3_wready", resp_ready, 2'b10);
        tick;
        req_valid = '0;
        #1 check("t3_awlen", m_aw_len, 3);
        check("t3_awburst", m_aw_burst, 2'b10);
        check("t3_awcache", m_aw_cache, 4'b0010);
        tick;
        set_req(0, 0, 0, 0, 32'h2000, 0, 0);
        #1 check("t3_other_line", resp_ready, 2'b01);
        tick;
        req_valid = '0;
        #1 check("t3_araddr_a", m_ar_addr, 32'h2000);
        tick;
        r_beat(0, 32'h77, 1, 0);
        #1 check("t3_rlast_a", resp_data_last, 2'b01);
        tick;
        m_r_valid = 1'b0;
        set_req(0, 0, 0, 0, 32'h1008, 0, 0);
        #1 check("t3_stall", resp_ready, 2'b00);
        tick;
        req_data_ok = 2'b11;
        m_w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_wdata[63:32] = 32'hA0 + i;
            #1 check("t3_wlast", m_w_last, i == 3);
            check("t3_wdata", m_w_data, 32'hA0 + i);
            check("t3_stall_w", resp_ready, 2'b00);
            tick;
        end
        m_w_ready = 1'b0;
        #1 check("t3_brdy", m_b_ready, 1);
        check("t3_stall_b", resp_ready, 2'b00);
        m_b_valid = 1'b1;
        m_b_id = 1;
        m_b_resp = 2'b11;
        #1 check("t3_back", resp_data_last, 2'b10);
        check("t3_berr", resp_err, 2'b10);
        check("t3_stall_bh", resp_ready, 2'b00);
        tick;
        m_b_valid = 1'b0;
        m_b_resp = 0;
        #1 check("t3_release", resp_ready, 2'b01);
        tick;
        req_valid = '0;
        #1 check("t3_araddr_b", m_ar_addr, 32'h1008);
        tick;
        r_beat(0, 32'h88, 1, 0);
        #1 check("t3_rlast_b", resp_data_last, 2'b01);
        tick;
        m_r_valid = 1'b0;

        // read error on beat 2 of 4, port1
        set_req(1, 0, 1, 0, 32'h4000, 0, 0);
        #1 check("t5_ready", resp_ready, 2'b10);
        tick;
        req_valid = '0;
        #1 check("t5_arid", m_ar_id, 1);
        tick;
        for (int i = 0; i < 4; i++) begin
            r_beat(1, 32'hE0 + i, i == 3, i == 1 ? 2'b10 : 2'b00);
            #1 check("t5_last", resp_data_last, i == 3 ? 2'b10 : 2'b00);
            check("t5_err", resp_err, i == 3 ? 2'b10 : 2'b00);
            tick;
        end
        m_r_valid = 1'b0;

        // reset in the middle of a read burst
        set_req(0, 0, 1, 0, 32'h5000, 0, 0);
        #1 check("t6_ready", resp_ready, 2'b01);
        tick;
        req_valid = '0;
        tick;
        for (int i = 0; i < 2; i++) begin
            r_beat(0, i, 0, 0);
            tick;
        end
        r_beat(0, 2, 0, 0);
        #1 check("t6_pre_rrdy", m_r_ready, 1);
        rst_n = 1'b0;
        #1 check("t6_rrdy", m_r_ready, 0);
        check("t6_arv", m_ar_valid, 0);
        check("t6_ok", resp_data_ok, 2'b00);
        m_r_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;

        // both ports reading continuously: grants alternate starting at port 0
        set_req(0, 0, 0, 0, 32'h100, 0, 0);
        set_req(1, 0, 0, 0, 32'h200, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1 check("t4_grant", resp_ready, k % 2 ? 2'b10 : 2'b01);
            tick;
            #1 check("t4_arid", m_ar_id, k % 2);
            check("t4_araddr", m_ar_addr, k % 2 ? 32'h200 : 32'h100);
            tick;
            r_beat(4'(k % 2), k, 1, 0);
            #1 check("t4_last", resp_data_last, k % 2 ? 2'b10 : 2'b01);
            tick;
            m_r_valid = 1'b0;
        end
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
